// File: rtl/rs232_rx_loader.sv
// rs232_rx_loader: receives 8N1 RS232 bytes and unpacks each byte LSB-first
// into 1-bit writes to the 256-entry codeword memory. After the last byte
// of a codeword it pulses the decoder start, then waits for the decoder to
// finish before loading the next codeword.
//
// Ports:
//   clk_s       - single clock
//   rstn_s      - asynchronous active-low reset
//   iRX         - serial line, idles high, asynchronous to clk_s
//   iDEC_DONE   - one-cycle decoder-finished pulse, re-arms the loader
//   oMEM_WE     - codeword memory write enable
//   oMEM_ADDR   - codeword memory write address {k, j}
//   oMEM_D      - codeword memory write data (one bit)
//   oSTART      - one-cycle decoder start pulse
//   oBUSY       - high from the first byte of a codeword until iDEC_DONE
//   oFRAME_ERR  - sticky, bad stop bit seen
//   oOVERRUN    - sticky, byte arrived while the loader was not accepting
module rs232_rx_loader #(
    parameter int unsigned CLK_DIV = 434,
    parameter int unsigned N_BYTES = 32
) (
    input  logic       clk_s,
    input  logic       rstn_s,
    input  logic       iRX,
    input  logic       iDEC_DONE,
    output logic       oMEM_WE,
    output logic [7:0] oMEM_ADDR,
    output logic       oMEM_D,
    output logic       oSTART,
    output logic       oBUSY,
    output logic       oFRAME_ERR,
    output logic       oOVERRUN
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned K_W   = 5;
    localparam int unsigned J_W   = 3;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLK_DIV - 1);
    localparam logic [K_W-1:0]   K_LAST  = K_W'(N_BYTES - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        LD_LOAD,
        LD_UNPACK,
        LD_FIRE,
        LD_WAIT
    } ld_state_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic             rx_s1;
    logic             rx_s2;
    logic             rx_prev;
    rx_state_t        rx_st, rx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bitc, bitc_nxt;
    logic [7:0]       shift, shift_nxt;
    logic [7:0]       rx_byte, rx_byte_nxt;
    logic             byte_valid, byte_valid_nxt;
    logic             ferr_nxt;

    // Synchroniser, edge history and receiver state register
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_st      <= RX_IDLE;
            cnt        <= '0;
            bitc       <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            oFRAME_ERR <= 1'b0;
        end else begin
            rx_s1      <= iRX;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            rx_st      <= rx_nxt;
            cnt        <= cnt_nxt;
            bitc       <= bitc_nxt;
            shift      <= shift_nxt;
            rx_byte    <= rx_byte_nxt;
            byte_valid <= byte_valid_nxt;
            oFRAME_ERR <= ferr_nxt;
        end
    end

    // Receiver next-state: start detect, mid-bit sampling, stop check
    always_comb begin
        rx_nxt         = rx_st;
        cnt_nxt        = CNT_W'(cnt + 1'b1);
        bitc_nxt       = bitc;
        shift_nxt      = shift;
        rx_byte_nxt    = rx_byte;
        byte_valid_nxt = 1'b0;
        ferr_nxt       = oFRAME_ERR;
        case (rx_st)
            RX_IDLE: begin
                cnt_nxt = '0;
                if (rx_prev && !rx_s2) begin
                    rx_nxt = RX_START;
                end
            end
            RX_START: begin
                if (cnt == HALF_M1) begin
                    cnt_nxt  = '0;
                    bitc_nxt = '0;
                    // A high line at mid-start is a glitch, not a byte
                    rx_nxt   = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s2, shift[7:1]};
                    bitc_nxt  = 3'(bitc + 1'b1);
                    if (bitc == 3'd7) begin
                        rx_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_nxt = '0;
                    rx_nxt  = RX_IDLE;
                    if (rx_s2) begin
                        rx_byte_nxt    = shift;
                        byte_valid_nxt = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
            end
            default: rx_nxt = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    ld_state_t      ld_st, ld_nxt;
    logic [K_W-1:0] k, k_nxt;
    logic [J_W-1:0] j, j_nxt;
    logic [J_W-1:0] j_inc;
    logic [7:0]     byte_reg, byte_reg_nxt;
    logic           we_nxt;
    logic [7:0]     addr_nxt;
    logic           d_nxt;
    logic           start_nxt;
    logic           busy_nxt;
    logic           ovr_nxt;

    // Loader state register and registered memory/decoder outputs
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            ld_st     <= LD_LOAD;
            k         <= '0;
            j         <= '0;
            byte_reg  <= '0;
            oMEM_WE   <= 1'b0;
            oMEM_ADDR <= '0;
            oMEM_D    <= 1'b0;
            oSTART    <= 1'b0;
            oBUSY     <= 1'b0;
            oOVERRUN  <= 1'b0;
        end else begin
            ld_st     <= ld_nxt;
            k         <= k_nxt;
            j         <= j_nxt;
            byte_reg  <= byte_reg_nxt;
            oMEM_WE   <= we_nxt;
            oMEM_ADDR <= addr_nxt;
            oMEM_D    <= d_nxt;
            oSTART    <= start_nxt;
            oBUSY     <= busy_nxt;
            oOVERRUN  <= ovr_nxt;
        end
    end

    // Loader next-state; outputs are computed one cycle ahead so the
    // registered write appears while the state register shows UNPACK
    always_comb begin
        ld_nxt       = ld_st;
        k_nxt        = k;
        j_nxt        = j;
        j_inc        = 3'(j + 1'b1);
        byte_reg_nxt = byte_reg;
        we_nxt       = 1'b0;
        addr_nxt     = oMEM_ADDR;
        d_nxt        = oMEM_D;
        start_nxt    = 1'b0;
        busy_nxt     = oBUSY;
        // Any byte arriving outside LOAD is dropped
        ovr_nxt      = oOVERRUN | (byte_valid && (ld_st != LD_LOAD));
        case (ld_st)
            LD_LOAD: begin
                if (byte_valid) begin
                    ld_nxt       = LD_UNPACK;
                    j_nxt        = '0;
                    byte_reg_nxt = rx_byte;
                    we_nxt       = 1'b1;
                    addr_nxt     = {k, 3'd0};
                    d_nxt        = rx_byte[0];
                    if (k == '0) begin
                        busy_nxt = 1'b1;
                    end
                end
            end
            LD_UNPACK: begin
                if (j != 3'd7) begin
                    j_nxt    = j_inc;
                    we_nxt   = 1'b1;
                    addr_nxt = {k, j_inc};
                    d_nxt    = byte_reg[j_inc];
                end else begin
                    j_nxt = '0;
                    if (k == K_LAST) begin
                        k_nxt     = '0;
                        ld_nxt    = LD_FIRE;
                        start_nxt = 1'b1;
                    end else begin
                        k_nxt  = K_W'(k + 1'b1);
                        ld_nxt = LD_LOAD;
                    end
                end
            end
            LD_FIRE: begin
                ld_nxt = LD_WAIT;
            end
            LD_WAIT: begin
                if (iDEC_DONE) begin
                    ld_nxt   = LD_LOAD;
                    k_nxt    = '0;
                    busy_nxt = 1'b0;
                end
            end
            default: ld_nxt = LD_LOAD;
        endcase
    end

endmodule

// File: tb/tb_rs232_rx_loader.sv
// Testbench for rs232_rx_loader: drives serial bytes, queues the expected
// memory writes per byte and compares them as the DUT emits them.
module tb_rs232_rx_loader;

    localparam int unsigned CLK_DIV = 16;
    localparam int unsigned N_BYTES = 32;

    logic       clk_s     = 1'b0;
    logic       rstn_s    = 1'b0;
    logic       iRX       = 1'b1;
    logic       iDEC_DONE = 1'b0;
    logic       oMEM_WE;
    logic [7:0] oMEM_ADDR;
    logic       oMEM_D;
    logic       oSTART;
    logic       oBUSY;
    logic       oFRAME_ERR;
    logic       oOVERRUN;

    int n_tests   = 0;
    int n_fail    = 0;
    int start_cnt = 0;

    logic [8:0] exp_q[$];
    logic       prev_we   = 1'b0;
    logic [7:0] prev_addr = '0;

    rs232_rx_loader #(
        .CLK_DIV(CLK_DIV),
        .N_BYTES(N_BYTES)
    ) dut (
        .clk_s     (clk_s),
        .rstn_s    (rstn_s),
        .iRX       (iRX),
        .iDEC_DONE (iDEC_DONE),
        .oMEM_WE   (oMEM_WE),
        .oMEM_ADDR (oMEM_ADDR),
        .oMEM_D    (oMEM_D),
        .oSTART    (oSTART),
        .oBUSY     (oBUSY),
        .oFRAME_ERR(oFRAME_ERR),
        .oOVERRUN  (oOVERRUN)
    );

    always #5 clk_s = ~clk_s;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor and start-pulse checker, sampled 1 ns after each edge
    always @(posedge clk_s) begin
        logic [8:0] e;
        #1;
        if (oMEM_WE) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_we", 32'(oMEM_WE), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("mem_write", 32'({oMEM_ADDR, oMEM_D}), 32'(e));
            end
        end
        if (oSTART) begin
            start_cnt++;
            check_val("start_after_255", 32'({prev_we, prev_addr}), 32'h1FF);
        end
        prev_we   = oMEM_WE;
        prev_addr = oMEM_ADDR;
    end

    task automatic push_byte(input logic [7:0] b, input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({8'(base + 8'(i)), b[i]});
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk_s);
        iRX = 1'b0;
        repeat (CLK_DIV) @(negedge clk_s);
        for (int i = 0; i < 8; i++) begin
            iRX = b[i];
            repeat (CLK_DIV) @(negedge clk_s);
        end
        iRX = stop_bit;
        repeat (CLK_DIV) @(negedge clk_s);
        iRX = 1'b1;
        repeat (CLK_DIV) @(negedge clk_s);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk_s);
            n++;
        end
        check_val(tag, 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk_s);
    endtask

    task automatic do_reset();
        @(negedge clk_s);
        rstn_s = 1'b0;
        iRX    = 1'b1;
        repeat (3) @(negedge clk_s);
        rstn_s = 1'b1;
        repeat (3) @(negedge clk_s);
    endtask

    initial begin
        // Reset state
        repeat (4) @(negedge clk_s);
        check_val("rst_we",    32'(oMEM_WE),    32'd0);
        check_val("rst_addr",  32'(oMEM_ADDR),  32'd0);
        check_val("rst_d",     32'(oMEM_D),     32'd0);
        check_val("rst_start", 32'(oSTART),     32'd0);
        check_val("rst_busy",  32'(oBUSY),      32'd0);
        check_val("rst_ferr",  32'(oFRAME_ERR), 32'd0);
        check_val("rst_ovr",   32'(oOVERRUN),   32'd0);
        rstn_s = 1'b1;
        repeat (3) @(negedge clk_s);

        // Single byte
        push_byte(8'hA5, 8'd0);
        send_byte(8'hA5, 1'b1);
        wait_drain("single_drain");
        check_val("single_busy",  32'(oBUSY), 32'd1);
        check_val("single_start", 32'(start_cnt), 32'd0);

        // Full codeword: byte k carries value k
        do_reset();
        for (int b = 0; b < int'(N_BYTES); b++) begin
            push_byte(8'(b), 8'(b * 8));
            send_byte(8'(b), 1'b1);
        end
        wait_drain("cw_drain");
        check_val("cw_start_cnt", 32'(start_cnt), 32'd1);
        check_val("cw_busy",      32'(oBUSY), 32'd1);
        check_val("cw_ovr",       32'(oOVERRUN), 32'd0);

        // Byte while waiting for the decoder, then re-arm
        send_byte(8'hFF, 1'b1);
        repeat (20) @(negedge clk_s);
        check_val("wait_ovr", 32'(oOVERRUN), 32'd1);
        iDEC_DONE = 1'b1;
        @(negedge clk_s);
        iDEC_DONE = 1'b0;
        repeat (2) @(negedge clk_s);
        check_val("done_busy_clr", 32'(oBUSY), 32'd0);
        push_byte(8'h3C, 8'd0);
        send_byte(8'h3C, 1'b1);
        wait_drain("rearm_drain");
        check_val("rearm_busy",  32'(oBUSY), 32'd1);
        check_val("rearm_start", 32'(start_cnt), 32'd1);

        // Bad stop bit drops the byte and leaves k alone
        do_reset();
        send_byte(8'h55, 1'b0);
        repeat (10) @(negedge clk_s);
        check_val("ferr_set",  32'(oFRAME_ERR), 32'd1);
        check_val("ferr_busy", 32'(oBUSY), 32'd0);
        push_byte(8'h01, 8'd0);
        send_byte(8'h01, 1'b1);
        wait_drain("ferr_next_drain");
        check_val("ferr_sticky", 32'(oFRAME_ERR), 32'd1);

        // False start glitch
        do_reset();
        @(negedge clk_s);
        iRX = 1'b0;
        repeat (4) @(negedge clk_s);
        iRX = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk_s);
        check_val("glitch_flags", 32'({oFRAME_ERR, oOVERRUN}), 32'd0);
        check_val("glitch_busy",  32'(oBUSY), 32'd0);
        push_byte(8'h5A, 8'd0);
        send_byte(8'h5A, 1'b1);
        wait_drain("glitch_next_drain");

        // Reset during the 5th byte's data phase
        do_reset();
        for (int b = 0; b < 4; b++) begin
            push_byte(8'(8'h11 * (b + 1)), 8'(b * 8));
            send_byte(8'(8'h11 * (b + 1)), 1'b1);
        end
        wait_drain("mid_pre_drain");
        check_val("mid_busy_pre", 32'(oBUSY), 32'd1);
        @(negedge clk_s);
        iRX = 1'b0;
        repeat (CLK_DIV) @(negedge clk_s);
        iRX = 1'b1;
        repeat (CLK_DIV) @(negedge clk_s);
        iRX = 1'b0;
        repeat (CLK_DIV / 2) @(negedge clk_s);
        #2;
        rstn_s = 1'b0;
        #1;
        check_val("mid_rst_outs",
                  32'({oMEM_WE, oMEM_ADDR, oMEM_D, oSTART, oBUSY, oFRAME_ERR, oOVERRUN}),
                  32'd0);
        iRX = 1'b1;
        repeat (3) @(negedge clk_s);
        rstn_s = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk_s);
        push_byte(8'h81, 8'd0);
        send_byte(8'h81, 1'b1);
        wait_drain("mid_after_drain");
        check_val("mid_after_busy", 32'(oBUSY), 32'd1);
        check_val("final_start_cnt", 32'(start_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
